// File: rtl/conv_tile_direct_6x6.sv
// Direct-form 3x3 correlation of one 6x6 tile into a 4x4 result, one MAC per cycle.
// This is a bit-exact, low-area stand-in for the Winograd F(4x4,3x3) tile core.
module conv_tile_direct_6x6 #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [0:5][0:5][DATA_W-1:0]      tile_in,
    input  logic [0:2][0:2][DATA_W-1:0]      kernel_in,
    output logic [0:3][0:3][DATA_W-1:0]      result_out,
    output logic                             done,
    output logic                             busy
);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t state, state_nxt;

    logic [0:5][0:5][DATA_W-1:0] tile_q;
    logic [0:2][0:2][DATA_W-1:0] kern_q;
    logic [0:3][0:3][DATA_W-1:0] res_q;
    logic [0:3][0:3][DATA_W-1:0] res_final;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     prod_ext;
    logic signed [ACC_W-1:0]     acc_sum;
    logic signed [2*DATA_W-1:0]  prod;
    logic [1:0]                  out_r, out_c, tap_a, tap_b;
    logic [2:0]                  row_idx, col_idx;
    logic                        last_tap, last_out;

    assign row_idx  = {1'b0, out_r} + {1'b0, tap_a};
    assign col_idx  = {1'b0, out_c} + {1'b0, tap_b};
    assign last_tap = (tap_a == 2'd2) && (tap_b == 2'd2);
    assign last_out = last_tap && (out_r == 2'd3) && (out_c == 2'd3);

    // Full-precision signed product, sign-extended into the accumulator width
    assign prod     = $signed(tile_q[row_idx][col_idx]) * $signed(kern_q[tap_a][tap_b]);
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign acc_sum  = acc + prod_ext;

    // The final output is still in acc_sum when result_out loads, so patch it in
    always_comb begin
        res_final       = res_q;
        res_final[3][3] = acc_sum[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: if (start) state_nxt = MAC;
            MAC: begin
                busy = 1'b1;
                if (last_out) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_q     <= '0;
            kern_q     <= '0;
            res_q      <= '0;
            result_out <= '0;
            acc        <= '0;
            out_r      <= '0;
            out_c      <= '0;
            tap_a      <= '0;
            tap_b      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tile_q <= tile_in;
                        kern_q <= kernel_in;
                        acc    <= '0;
                        out_r  <= '0;
                        out_c  <= '0;
                        tap_a  <= '0;
                        tap_b  <= '0;
                    end
                end
                MAC: begin
                    if (last_tap) begin
                        // Wrap-around truncation, no saturation
                        res_q[out_r][out_c] <= acc_sum[DATA_W-1:0];
                        acc   <= '0;
                        tap_a <= '0;
                        tap_b <= '0;
                        if (out_c == 2'd3) begin
                            out_c <= '0;
                            out_r <= out_r + 2'd1;
                        end else begin
                            out_c <= out_c + 2'd1;
                        end
                        if (last_out) result_out <= res_final;
                    end else begin
                        acc <= acc_sum;
                        if (tap_b == 2'd2) begin
                            tap_b <= '0;
                            tap_a <= tap_a + 2'd1;
                        end else begin
                            tap_b <= tap_b + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_tile_direct_6x6.sv
// Directed self-checking bench for conv_tile_direct_6x6.
module tb_conv_tile_direct_6x6;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        start = 1'b0;
    logic [0:5][0:5][DATA_W-1:0] tile_in = '0;
    logic [0:2][0:2][DATA_W-1:0] kernel_in = '0;
    logic [0:3][0:3][DATA_W-1:0] result_out;
    logic                        done;
    logic                        busy;

    logic [0:3][0:3][DATA_W-1:0] exp_res;

    int n_vec = 0;
    int n_err = 0;
    int lat, bcyc, npulse;

    conv_tile_direct_6x6 #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .tile_in    (tile_in),
        .kernel_in  (kernel_in),
        .result_out (result_out),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_res(input string tag);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                chk($sformatf("%s[%0d][%0d]", tag, r, c),
                    64'(result_out[r][c]), 64'(exp_res[r][c]));
    endtask

    // Called at a negedge with inputs set; returns just after the accepting edge
    task automatic launch();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // n counts edges since acceptance; optionally pokes start once at n == poke_at
    task automatic wait_done(input int poke_at, output int l, output int b);
        l = 0;
        b = 0;
        for (int n = 0; n < 400; n++) begin
            start = (n == poke_at);
            if (busy) b++;
            if (done) begin
                l = n;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic count_done(input int cycles, output int p);
        p = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (done) p++;
        end
    endtask

    task automatic set_ones();
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) tile_in[i][j] = 16'd1;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++) kernel_in[a][b] = 16'd1;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_res00", 64'(result_out[0][0]), 64'd0);
        chk("rst_res33", 64'(result_out[3][3]), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // All ones: latency and busy width
        set_ones();
        launch();
        wait_done(-1, lat, bcyc);
        chk("ones_latency", 64'(lat), 64'd144);
        chk("ones_busy_cycles", 64'(bcyc), 64'd145);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) exp_res[r][c] = 16'd9;
        chk_res("ones");
        @(negedge clk);
        chk("ones_done_drop", 64'(done), 64'd0);
        chk("ones_busy_drop", 64'(busy), 64'd0);

        // Ramp tile; tile changed after capture; second start at cycle 50 ignored
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) tile_in[i][j] = 16'(6*i + j);
        launch();
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) tile_in[i][j] = 16'h1234;
        wait_done(49, lat, bcyc);
        chk("ramp_latency", 64'(lat), 64'd144);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) exp_res[r][c] = 16'(54*r + 9*c + 63);
        chk_res("ramp");
        count_done(160, npulse);
        chk("ramp_no_extra_done", 64'(npulse), 64'd0);

        // Laplacian on constant tile -> zero
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++) kernel_in[a][b] = (a == 1 && b == 1) ? 16'd8 : 16'hFFFF;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) tile_in[i][j] = 16'd10;
        launch();
        wait_done(-1, lat, bcyc);
        exp_res = '0;
        chk_res("lap_const");
        @(negedge clk);

        // Laplacian on impulse at [2][2]
        tile_in = '0;
        tile_in[2][2] = 16'd100;
        launch();
        wait_done(-1, lat, bcyc);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                exp_res[r][c] = (r == 1 && c == 1) ? 16'd800 :
                                (r <= 2 && c <= 2) ? 16'hFF9C : 16'h0000;
        chk_res("lap_imp");
        @(negedge clk);

        // Overflow wraps: 9 * 0x7FFF^2 = 0x23FF70009
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) tile_in[i][j] = 16'h7FFF;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++) kernel_in[a][b] = 16'h7FFF;
        launch();
        wait_done(-1, lat, bcyc);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) exp_res[r][c] = 16'h0009;
        chk_res("ovf");
        @(negedge clk);

        // Start held high: done pulses every 146 cycles
        set_ones();
        start = 1'b1;
        lat = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
        bcyc = 0;
        for (int n = 1; n < 400; n++) begin
            @(negedge clk);
            if (done) begin
                bcyc = n;
                break;
            end
        end
        start = 1'b0;
        chk("cont_period", 64'(bcyc), 64'd146);
        chk("cont_res00", 64'(result_out[0][0]), 64'd9);
        @(negedge clk);
        @(negedge clk);
        chk("cont_idle", 64'(busy), 64'd0);

        // Reset mid-job abandons it
        launch();
        for (int n = 0; n < 59; n++) @(negedge clk);
        chk("mid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_res00", 64'(result_out[0][0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        count_done(200, npulse);
        chk("mid_no_done", 64'(npulse), 64'd0);
        launch();
        wait_done(-1, lat, bcyc);
        chk("post_rst_latency", 64'(lat), 64'd144);
        chk("post_rst_res12", 64'(result_out[1][2]), 64'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
